vga_frame_reader: RTL and testbench

Display-side consumer of the camera frame buffer. It generates 640x480@60 Hz VGA timing and drives the buffer's pixel address outputs `x_addr` / `y_addr`. It takes the 8-bit grayscale `value` returned after the buffer's fixed read latency and drives latency-aligned RGB, sync and blank signals to the VGA DAC. It runs entirely in the buffer's read-clock domain (25 MHz pixel clock), and a selectable colour-bar test pattern replaces camera data for display bring-up.

---
 rtl/vga_frame_reader.sv | 161 ++++++++++++++++
 tb/tb_vga_frame_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA timing generator and frame-buffer reader.
// Drives pixel addresses to the frame buffer, takes the grayscale value back
// after the buffer read latency and produces latency-aligned RGB, syncs and
// blank for the VGA DAC. A colour-bar pattern can replace the camera data.
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RD_LAT   = 2
) (
  input  logic       rd_clk,
  input  logic       reset,
  input  logic       test_pattern,
  input  logic [7:0] value,
  output logic [9:0] x_addr,
  output logic [9:0] y_addr,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hs,
  output logic       vga_vs,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       frame_start
);

  // Counter-width copies of the timing constants, so every compare is 10 bits.
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
  // Eight equal-width colour bars across the visible line.
  localparam logic [9:0] BAR_W    = 10'(H_ACTIVE / 8);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_vis;
  logic       v_vis;
  logic       act;
  logic       hs_raw;
  logic       vs_raw;

  // Alignment pipeline: stage RD_LAT-1 lines up with the returned value.
  logic [RD_LAT-1:0] act_d;
  logic [RD_LAT-1:0] hs_d;
  logic [RD_LAT-1:0] vs_d;
  logic [9:0]        hx_d [RD_LAT];

  logic       act_dly;
  logic [9:0] hx_dly;
  logic [2:0] bar_idx;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;

  // Horizontal and vertical position counters; the line wrap advances the row.
  always_ff @(posedge rd_clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Undelayed decodes of the counters: visibility, raw syncs and addresses.
  assign h_vis  = (h_cnt < H_ACT);
  assign v_vis  = (v_cnt < V_ACT);
  assign act    = h_vis && v_vis;
  assign hs_raw = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vs_raw = (v_cnt >= VS_START) && (v_cnt < VS_END);
  assign x_addr = h_vis ? h_cnt : '0;
  assign y_addr = v_vis ? v_cnt : '0;

  // Delay the timing signals by the buffer read latency.
  always_ff @(posedge rd_clk or posedge reset) begin
    // NOTE: this delay line is built from ordinary flops rather than a RAM, so
    // it can be cleared; that keeps blank and syncs inactive until real pixel
    // data reaches the output stage.
    if (reset) begin
      act_d <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
      for (int i = 0; i < RD_LAT; i++) hx_d[i] <= '0;
    end else begin
      act_d[0] <= act;
      hs_d[0]  <= hs_raw;
      vs_d[0]  <= vs_raw;
      hx_d[0]  <= h_cnt;
      for (int i = 1; i < RD_LAT; i++) begin
        act_d[i] <= act_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
        hx_d[i]  <= hx_d[i-1];
      end
    end
  end

  assign act_dly = act_d[RD_LAT-1];
  assign hx_dly  = hx_d[RD_LAT-1];
  assign bar_idx = 3'(hx_dly / BAR_W);

  // Pixel colour selection: blank, camera grayscale, or colour bars.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise the
    // tool infers latches for the branches that leave a channel untouched.
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (act_dly) begin
      if (test_pattern) begin
        pix_r = {8{bar_idx[2]}};
        pix_g = {8{bar_idx[1]}};
        pix_b = {8{bar_idx[0]}};
      end else begin
        pix_r = value;
        pix_g = value;
        pix_b = value;
      end
    end
  end

  // Output register stage toward the DAC; syncs are active-low.
  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= pix_r;
      vga_g       <= pix_g;
      vga_b       <= pix_b;
      vga_hs      <= ~hs_d[RD_LAT-1];
      vga_vs      <= ~vs_d[RD_LAT-1];
      vga_blank_n <= act_dly;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  // No sync-on-green.
  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Testbench for vga_frame_reader. Horizontal timing is the real 800-clock
// line; the vertical parameters are shrunk to a 15-line frame (8 visible,
// vsync on lines 10-11, 12000-clock frame) so whole frames fit in the run.
// cyc counts rising edges since reset release; outputs seen after edge k
// describe counter position k-3 (2-clock buffer latency + output register).
module tb_vga_frame_reader;

  localparam int TV_ACT  = 8;
  localparam int TV_FP   = 2;
  localparam int TV_SYNC = 2;
  localparam int TV_BP   = 3;
  localparam int FRAME   = 800 * 15;

  localparam int S_BLANK = 0;
  localparam int S_HS    = 1;
  localparam int S_VS    = 2;
  localparam int S_FS    = 3;

  logic       rd_clk = 1'b0;
  logic       reset = 1'b1;
  logic       test_pattern = 1'b0;
  logic [7:0] value;
  logic [9:0] x_addr, y_addr;
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fs_cnt = 0;

  vga_frame_reader #(
    .V_ACTIVE(TV_ACT), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP)
  ) dut (
    .rd_clk(rd_clk), .reset(reset), .test_pattern(test_pattern), .value(value),
    .x_addr(x_addr), .y_addr(y_addr), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .frame_start(frame_start)
  );

  always #5 rd_clk = ~rd_clk;

  // Frame-buffer model: two-clock read latency returning x_addr[7:0];
  // frc overrides the returned data with a marker value.
  logic [7:0] bp0, bp1;
  logic       frc = 1'b0;
  always @(posedge rd_clk) begin
    bp0 <= x_addr[7:0];
    bp1 <= bp0;
  end
  assign value = frc ? 8'hC3 : bp1;

  always @(posedge rd_clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(posedge rd_clk) if (frame_start) fs_cnt <= fs_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
               name, got, got, exp, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge rd_clk);
  endtask

  task automatic wait_cyc(input int t);
    int guard = 0;
    while (cyc < t && guard < 100000) begin
      step();
      guard++;
    end
    check("schedule", cyc, t);
  endtask

  function automatic logic get_sig(input int sel);
    case (sel)
      S_BLANK: return vga_blank_n;
      S_HS:    return vga_hs;
      S_VS:    return vga_vs;
      default: return frame_start;
    endcase
  endfunction

  // Advance until the selected output equals lvl; at = cyc or -1 on timeout.
  task automatic wait_level(input int sel, input logic lvl, input int limit, output int at);
    at = -1;
    while (cyc <= limit) begin
      if (get_sig(sel) === lvl) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rgb"}, {8'h0, vga_r, vga_g, vga_b}, 32'h0);
    check({tag, "_hs"}, vga_hs, 1);
    check({tag, "_vs"}, vga_vs, 1);
    check({tag, "_blank_n"}, vga_blank_n, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_xy"}, {x_addr, y_addr}, 0);
  endtask

  typedef struct {
    int         p;     // linear counter position h + 800*v
    bit         tp;
    bit         frc;
    logic [7:0] r, g, b;
    bit         bl;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int t_br, t_bf, t_hf1, t_hr, t_hf2, t_vf1, t_vr, t_vf2, t_fs;

    vecs = '{
      '{1,    0, 0, 8'h01, 8'h01, 8'h01, 1},
      '{100,  0, 0, 8'h64, 8'h64, 8'h64, 1},
      '{255,  0, 0, 8'hFF, 8'hFF, 8'hFF, 1},
      '{256,  0, 0, 8'h00, 8'h00, 8'h00, 1},
      '{639,  0, 0, 8'h7F, 8'h7F, 8'h7F, 1},
      '{640,  0, 1, 8'h00, 8'h00, 8'h00, 0},
      '{700,  1, 1, 8'h00, 8'h00, 8'h00, 0},
      '{800,  1, 0, 8'h00, 8'h00, 8'h00, 1},
      '{879,  1, 0, 8'h00, 8'h00, 8'h00, 1},
      '{880,  1, 0, 8'h00, 8'h00, 8'hFF, 1},
      '{960,  1, 0, 8'h00, 8'hFF, 8'h00, 1},
      '{1040, 1, 0, 8'h00, 8'hFF, 8'hFF, 1},
      '{1120, 1, 0, 8'hFF, 8'h00, 8'h00, 1},
      '{1200, 1, 0, 8'hFF, 8'h00, 8'hFF, 1},
      '{1280, 1, 0, 8'hFF, 8'hFF, 8'h00, 1},
      '{1360, 1, 0, 8'hFF, 8'hFF, 8'hFF, 1},
      '{1439, 1, 0, 8'hFF, 8'hFF, 8'hFF, 1},
      '{1440, 1, 0, 8'h00, 8'h00, 8'h00, 0},
      '{1605, 0, 1, 8'hC3, 8'hC3, 8'hC3, 1},
      '{1606, 0, 0, 8'h06, 8'h06, 8'h06, 1},
      '{1607, 1, 0, 8'h00, 8'h00, 8'h00, 1},
      '{1608, 0, 0, 8'h08, 8'h08, 8'h08, 1},
      '{1680, 1, 0, 8'h00, 8'h00, 8'hFF, 1},
      '{1681, 0, 0, 8'h51, 8'h51, 8'h51, 1}
    };

    // Power-on reset, 10 clocks.
    repeat (10) step();
    check_reset_vals("por");
    check("por_sync_n", vga_sync_n, 0);
    reset = 1'b0;
    #1;
    check("rel_xy", {x_addr, y_addr}, 0);
    step();
    check("c1_frame_start", frame_start, 1);
    check("c1_x", x_addr, 1);
    check("c1_blank_n", vga_blank_n, 0);
    step();
    check("c2_frame_start", frame_start, 0);
    check("c2_blank_n", vga_blank_n, 0);
    step();
    check("c3_blank_n", vga_blank_n, 1);
    check("c3_r", vga_r, 0);

    // Table: set inputs one clock before the output register samples them.
    for (int i = 0; i < vecs.size(); i++) begin
      wait_cyc(vecs[i].p + 2);
      test_pattern = vecs[i].tp;
      frc = vecs[i].frc;
      step();
      check($sformatf("vec%0d_rgb", i), {8'h0, vga_r, vga_g, vga_b},
            {8'h0, vecs[i].r, vecs[i].g, vecs[i].b});
      check($sformatf("vec%0d_blank_n", i), vga_blank_n, vecs[i].bl);
    end
    test_pattern = 1'b0;
    frc = 1'b0;

    // Address boundaries at the end of visible line 2.
    wait_cyc(2239);
    check("x_last", {x_addr, y_addr}, {10'd639, 10'd2});
    step();
    check("x_wrap", {x_addr, y_addr}, {10'd0, 10'd2});

    // Horizontal timing on line 3.
    wait_cyc(2400);
    wait_level(S_BLANK, 1'b1, 4000, t_br);
    wait_level(S_BLANK, 1'b0, 4000, t_bf);
    wait_level(S_HS, 1'b0, 4000, t_hf1);
    wait_level(S_HS, 1'b1, 4000, t_hr);
    wait_level(S_HS, 1'b0, 4000, t_hf2);
    check("blank_rise", t_br, 2403);
    check("blank_width", t_bf - t_br, 640);
    check("hs_start", t_hf1 - t_br, 656);
    check("hs_width", t_hr - t_hf1, 96);
    check("hs_period", t_hf2 - t_hf1, 800);

    // Vertical address: last visible row, then held 0 in vertical blank.
    wait_cyc(5610);
    check("y_last", y_addr, 7);
    wait_cyc(6405);
    check("y_vblank", {x_addr, y_addr}, {10'd5, 10'd0});

    // Vertical sync: starts at line 10, two lines wide, one per frame.
    wait_level(S_VS, 1'b0, 22000, t_vf1);
    wait_level(S_VS, 1'b1, 22000, t_vr);
    wait_level(S_VS, 1'b0, 22000, t_vf2);
    check("vs_start", t_vf1, 8003);
    check("vs_width", t_vr - t_vf1, 1600);
    check("vs_period", t_vf2 - t_vf1, FRAME);

    // frame_start: one single-clock pulse per frame.
    wait_level(S_FS, 1'b1, 26000, t_fs);
    check("fs_third", t_fs, 2 * FRAME + 1);
    step();
    check("fs_one_clock", frame_start, 0);
    check("fs_count", fs_cnt, 3);

    // Mid-frame asynchronous reset at h=300, v=5.
    wait_cyc(2 * FRAME + 4300);
    check("pre_rst_blank_n", vga_blank_n, 1);
    check("pre_rst_r", vga_r, 8'd41);
    check("pre_rst_xy", {x_addr, y_addr}, {10'd300, 10'd5});
    reset = 1'b1;
    #1;
    check_reset_vals("async");
    repeat (3) step();
    check_reset_vals("held");
    reset = 1'b0;
    #1;
    check("rel2_xy", {x_addr, y_addr}, 0);
    step();
    check("rel2_fs", frame_start, 1);
    check("rel2_x", x_addr, 1);
    step();
    wait_level(S_FS, 1'b1, FRAME + 100, t_fs);
    check("rel2_fs_next", t_fs, FRAME + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
